// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit:
// FSM states, instruction classes, ALU codes, opcode/funct values and mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_ILL
  } cls_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SLLV = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_SRAV = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SRLV = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

endpackage

// File: rtl/mc_dec.sv
// Combinational instruction decoder: opcode/funct to class, ALU code,
// immediate extension mode and destination-register select.
module mc_dec
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [3:0] alu_op,
  output logic       ext_op,
  output logic [1:0] reg_dst,
  output logic       legal
);

  always_comb begin
    cls     = CL_ILL;
    alu_op  = ALU_ADD;
    ext_op  = 1'b0;
    reg_dst = RD_RT;
    case (opcode)
      OP_RTYPE: begin
        cls     = CL_R;
        reg_dst = RD_RD;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_SLLV:         alu_op = ALU_SLLV;
          FN_SRLV:         alu_op = ALU_SRLV;
          FN_SRAV:         alu_op = ALU_SRAV;
          FN_JR:           cls    = CL_JR;
          default:         cls    = CL_ILL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin cls = CL_I; ext_op = 1'b1; end
      OP_SLTI:  begin cls = CL_I; alu_op = ALU_SLT;  ext_op = 1'b1; end
      OP_SLTIU: begin cls = CL_I; alu_op = ALU_SLTU; ext_op = 1'b1; end
      OP_ANDI:  begin cls = CL_I; alu_op = ALU_AND; end
      OP_ORI:   begin cls = CL_I; alu_op = ALU_OR;  end
      OP_XORI:  begin cls = CL_I; alu_op = ALU_XOR; end
      OP_LUI:   begin cls = CL_I; alu_op = ALU_LUI; end
      OP_LW:    begin cls = CL_LW;  ext_op = 1'b1; end
      OP_SW:    begin cls = CL_SW;  ext_op = 1'b1; end
      OP_BEQ:   begin cls = CL_BEQ; ext_op = 1'b1; end
      OP_BNE:   begin cls = CL_BNE; ext_op = 1'b1; end
      OP_J:     cls = CL_J;
      OP_JAL:   cls = CL_JAL;
      default:  cls = CL_ILL;
    endcase
    legal = (cls != CL_ILL);
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the single-ALU MIPS-subset datapath.
// Optional MC_CTRL_PERF_EN adds cycle and retired-instruction counters.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int INIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_op,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  localparam logic [1:0] INIT_LAST = 2'(INIT_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [1:0] init_cnt_reg;
  cls_t       cls_reg;
  logic [3:0] alu_reg;
  logic       ext_reg;
  logic [1:0] dst_reg;
  logic       illegal_reg;

  cls_t       dec_cls;
  logic [3:0] dec_alu;
  logic       dec_ext;
  logic [1:0] dec_dst;
  logic       dec_legal;

  mc_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (dec_cls),
    .alu_op (dec_alu),
    .ext_op (dec_ext),
    .reg_dst(dec_dst),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_INIT;
      init_cnt_reg <= '0;
      cls_reg      <= CL_R;
      alu_reg      <= '0;
      ext_reg      <= 1'b0;
      dst_reg      <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_INIT && init_cnt_reg != INIT_LAST)
        init_cnt_reg <= init_cnt_reg + 2'd1;
      // IR is stable in DECODE; later states only see the captured fields
      if (state_reg == S_DECODE) begin
        cls_reg <= dec_cls;
        alu_reg <= dec_alu;
        ext_reg <= dec_ext;
        dst_reg <= dec_dst;
      end
      if (state_next == S_TRAP)
        illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALU;
    case (state_reg)
      S_INIT: if (init_cnt_reg == INIT_LAST) state_next = S_FETCH;
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // branch target computed speculatively into ALUOut
        alu_src_b = SRCB_BOFF;
        ext_op    = 1'b1;
        if (!dec_legal) state_next = S_TRAP;
        else begin
          case (dec_cls)
            CL_R, CL_I:          state_next = S_EXEC;
            CL_LW, CL_SW:        state_next = S_MEM_ADDR;
            CL_BEQ, CL_BNE:      state_next = S_BRANCH;
            CL_J, CL_JAL, CL_JR: state_next = S_JUMP;
            default:             state_next = S_TRAP;
          endcase
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = (cls_reg == CL_R) ? SRCB_RT : SRCB_IMM;
        ext_op     = ext_reg;
        alu_op     = alu_reg;
        state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_we     = 1'b1;
        reg_dst    = dst_reg;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        ext_op     = 1'b1;
        state_next = (cls_reg == CL_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        if (mem_ready) state_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = M2R_MDR;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_ALUOUT;
        pc_we      = (cls_reg == CL_BEQ) ? zero : ~zero;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = (cls_reg == CL_JR) ? PC_RS : PC_JUMP;
        if (cls_reg == CL_JAL) begin
          reg_we     = 1'b1;
          reg_dst    = RD_RA;
          mem_to_reg = M2R_PC;
        end
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_INIT;
    endcase
  end

  assign illegal = illegal_reg;

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state_reg != S_INIT && state_reg != S_TRAP)
        cyc_cnt <= cyc_cnt + 32'd1;
      // entering FETCH from anywhere but INIT or a FETCH stall retires one instruction
      if (state_next == S_FETCH && state_reg != S_FETCH && state_reg != S_INIT)
        ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed test-plan scenarios plus a
// randomized run checked every cycle against a queue-based instruction model.
module tb_mc_ctrl;

  localparam int INIT_CYCLES = 1;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic mem_rd, mem_wr, ir_we, pc_we, alu_src_a, ext_op, reg_we, illegal;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [3:0] alu_op;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mc_ctrl #(.INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rd, wr, ir, pcw;
    logic [1:0] pcs;
    logic sa;
    logic [1:0] sb;
    logic ext;
    logic [3:0] alu;
    logic rw;
    logic [1:0] dst, m2r;
    logic ill;
  } ov_t;

  ov_t act;
  assign act = {mem_rd, mem_wr, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                ext_op, alu_op, reg_we, reg_dst, mem_to_reg, illegal};

  typedef enum int {P_INIT, P_FETCH, P_DEC, P_EXEC, P_WBA, P_ADDR, P_MRD,
                    P_WBM, P_MWR, P_BR, P_JMP, P_TRAP} phase_t;
  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_BAD} kind_t;

  int n_tests = 0;
  int n_fail  = 0;

  // model: current phase plus the phases still owed by the instruction in flight
  phase_t cur;
  phase_t q[$];
  kind_t  mk;
  logic [3:0] malu;
  logic mext, mcare;
  logic [31:0] mcyc, mret;

  logic [5:0] rfns [17] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                            6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd8};
  logic [5:0] iops [14] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd11,
                            6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic classify(input logic [5:0] op, input logic [5:0] fn, output kind_t k,
                          output logic [3:0] alu, output logic ext, output logic care);
    k = K_BAD; alu = 4'd0; ext = 1'b0; care = 1'b1;
    case (op)
      6'd0: begin
        k = K_R; care = 1'b0;
        case (fn)
          6'd32, 6'd33: alu = 4'd0;
          6'd34, 6'd35: alu = 4'd1;
          6'd36: alu = 4'd4;  6'd37: alu = 4'd3;  6'd38: alu = 4'd2;
          6'd39: alu = 4'd6;  6'd42: alu = 4'd13; 6'd43: alu = 4'd5;
          6'd0:  alu = 4'd7;  6'd2:  alu = 4'd8;  6'd3:  alu = 4'd11;
          6'd4:  alu = 4'd10; 6'd6:  alu = 4'd15; 6'd7:  alu = 4'd12;
          6'd8:  k = K_JR;
          default: k = K_BAD;
        endcase
      end
      6'd8, 6'd9: begin k = K_I; alu = 4'd0;  ext = 1'b1; end
      6'd10:      begin k = K_I; alu = 4'd13; ext = 1'b1; end
      6'd11:      begin k = K_I; alu = 4'd5;  ext = 1'b1; end
      6'd12:      begin k = K_I; alu = 4'd4; end
      6'd13:      begin k = K_I; alu = 4'd3; end
      6'd14:      begin k = K_I; alu = 4'd2; end
      6'd15:      begin k = K_I; alu = 4'd9; care = 1'b0; end
      6'd35: k = K_LW;
      6'd43: k = K_SW;
      6'd4:  k = K_BEQ;
      6'd5:  k = K_BNE;
      6'd2:  k = K_J;
      6'd3:  k = K_JAL;
      default: k = K_BAD;
    endcase
  endtask

  task automatic model_reset();
    cur = P_INIT;
    q.delete();
    for (int i = 0; i < INIT_CYCLES - 1; i++) q.push_back(P_INIT);
    q.push_back(P_FETCH);
    mcyc = 32'd0;
    mret = 32'd0;
  endtask

  task automatic model_advance();
    if (cur != P_INIT && cur != P_TRAP) mcyc = mcyc + 32'd1;
    if (cur == P_TRAP) return;
    if ((cur == P_FETCH || cur == P_MRD || cur == P_MWR) && !mem_ready) return;
    if (cur == P_FETCH) q.push_back(P_DEC);
    if (cur == P_DEC) begin
      classify(opcode, funct, mk, malu, mext, mcare);
      case (mk)
        K_R, K_I:      begin q.push_back(P_EXEC); q.push_back(P_WBA); end
        K_LW:          begin q.push_back(P_ADDR); q.push_back(P_MRD); q.push_back(P_WBM); end
        K_SW:          begin q.push_back(P_ADDR); q.push_back(P_MWR); end
        K_BEQ, K_BNE:  q.push_back(P_BR);
        K_J, K_JAL, K_JR: q.push_back(P_JMP);
        default:       q.push_back(P_TRAP);
      endcase
    end
    if (q.size() == 0) begin
      cur  = P_FETCH;
      mret = mret + 32'd1;
    end else begin
      cur = q.pop_front();
    end
  endtask

  task automatic model_expect(output ov_t e, output ov_t c);
    e = '0;
    c = '1;
    case (cur)
      P_FETCH: begin e.rd = 1'b1; e.sb = 2'b01; e.ir = mem_ready; e.pcw = mem_ready; end
      P_DEC:   begin e.sb = 2'b11; e.ext = 1'b1; end
      P_EXEC:  begin
        e.sa = 1'b1; e.sb = (mk == K_R) ? 2'b00 : 2'b10;
        e.alu = malu; e.ext = mext; c.ext = mcare;
      end
      P_WBA:   begin e.rw = 1'b1; e.dst = (mk == K_R) ? 2'b01 : 2'b00; end
      P_ADDR:  begin e.sa = 1'b1; e.sb = 2'b10; e.ext = 1'b1; end
      P_MRD:   e.rd = 1'b1;
      P_WBM:   begin e.rw = 1'b1; e.m2r = 2'b01; end
      P_MWR:   e.wr = 1'b1;
      P_BR:    begin
        e.sa = 1'b1; e.alu = 4'd1; e.pcs = 2'b01;
        e.pcw = (mk == K_BEQ) ? zero : !zero;
      end
      P_JMP:   begin
        e.pcw = 1'b1; e.pcs = (mk == K_JR) ? 2'b11 : 2'b10;
        if (mk == K_JAL) begin e.rw = 1'b1; e.dst = 2'b10; e.m2r = 2'b10; end
      end
      P_TRAP:  e.ill = 1'b1;
      default: ;
    endcase
  endtask

  task automatic model_compare();
    ov_t e, c;
    model_expect(e, c);
    n_tests++;
    if (((act ^ e) & c) != '0) begin
      n_fail++;
      $display("FAIL cycle_model phase=%0d got=%h want=%h care=%h", cur, act, e, c);
    end
`ifdef MC_CTRL_PERF_EN
    chk("cyc_cnt", cyc_cnt, mcyc);
    chk("ret_cnt", ret_cnt, mret);
`endif
  endtask

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input logic z);
    @(posedge clk);
    if (!rst) model_advance();
    #1;
    opcode = op; funct = fn; mem_ready = rdy; zero = z;
    @(negedge clk);
    model_compare();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 model_compare();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    model_compare();
  endtask

  initial begin
    int n;
    int trap_cnt;
    logic [5:0] op, fn;
    int k;

    rst = 1'b1; opcode = 6'd0; funct = 6'd32; zero = 1'b0; mem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    model_compare();
    chk("init_all_zero", 32'(act), 32'd0);

    // add
    cyc(6'd0, 6'd32, 1'b1, 1'b0);
    chk("fetch_mem_rd", mem_rd, 1);
    chk("fetch_ir_we", ir_we, 1);
    cyc(6'd0, 6'd32, 1'b1, 1'b0);
    cyc(6'd0, 6'd32, 1'b1, 1'b0);
    chk("add_exec_alu", alu_op, 4'b0000);
    chk("add_exec_srcb", alu_src_b, 2'b00);
    cyc(6'd0, 6'd32, 1'b1, 1'b0);
    chk("add_wb_reg_we", reg_we, 1);
    chk("add_wb_reg_dst", reg_dst, 2'b01);

    // lw with three wait cycles
    cyc(6'd35, 6'd0, 1'b1, 1'b0);
    cyc(6'd35, 6'd0, 1'b1, 1'b0);
    cyc(6'd35, 6'd0, 1'b1, 1'b0);
    n = 0;
    repeat (3) begin cyc(6'd35, 6'd0, 1'b0, 1'b0); n += int'(mem_rd); end
    cyc(6'd35, 6'd0, 1'b1, 1'b0);
    n += int'(mem_rd);
    chk("lw_mem_rd_cycles", n, 4);
    cyc(6'd35, 6'd0, 1'b1, 1'b0);
    chk("lw_wb_mem_to_reg", mem_to_reg, 2'b01);
    chk("lw_wb_reg_we", reg_we, 1);

    // beq / bne with zero=1
    cyc(6'd4, 6'd0, 1'b1, 1'b1);
    cyc(6'd4, 6'd0, 1'b1, 1'b1);
    cyc(6'd4, 6'd0, 1'b1, 1'b1);
    chk("beq_pc_we", pc_we, 1);
    chk("beq_pc_src", pc_src, 2'b01);
    chk("beq_alu_op", alu_op, 4'b0001);
    cyc(6'd5, 6'd0, 1'b1, 1'b1);
    cyc(6'd5, 6'd0, 1'b1, 1'b1);
    cyc(6'd5, 6'd0, 1'b1, 1'b1);
    chk("bne_pc_we", pc_we, 0);

    // jal
    cyc(6'd3, 6'd0, 1'b1, 1'b0);
    cyc(6'd3, 6'd0, 1'b1, 1'b0);
    cyc(6'd3, 6'd0, 1'b1, 1'b0);
    chk("jal_pc_we", pc_we, 1);
    chk("jal_reg_we", reg_we, 1);
    chk("jal_reg_dst", reg_dst, 2'b10);
    chk("jal_mem_to_reg", mem_to_reg, 2'b10);

    // sw stalled, then asynchronous reset mid-wait
    cyc(6'd43, 6'd0, 1'b1, 1'b0);
    cyc(6'd43, 6'd0, 1'b1, 1'b0);
    cyc(6'd43, 6'd0, 1'b1, 1'b0);
    cyc(6'd43, 6'd0, 1'b0, 1'b0);
    chk("sw_mem_wr", mem_wr, 1);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("sw_rst_drops_mem_wr", mem_wr, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("restart_init_zero", 32'(act), 32'd0);
    cyc(6'd63, 6'd63, 1'b1, 1'b0);
    chk("restart_fetch", mem_rd, 1);

    // illegal opcode traps and stays
    cyc(6'd63, 6'd63, 1'b1, 1'b0);
    cyc(6'd63, 6'd63, 1'b1, 1'b0);
    chk("trap_illegal", illegal, 1);
    repeat (3) cyc(6'd0, 6'd32, 1'b1, 1'b0);
    chk("trap_sticky", illegal, 1);
    do_reset();
    chk("trap_cleared", illegal, 0);

    // randomized run
    trap_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      k = $urandom_range(0, 40);
      if (k == 0) begin op = 6'($urandom); fn = 6'($urandom); end
      else if (k <= 17) begin op = 6'd0; fn = rfns[k-1]; end
      else begin op = iops[(k-18) % 14]; fn = 6'($urandom); end
      cyc(op, fn, ($urandom_range(0, 3) != 0), 1'($urandom));
      trap_cnt = (cur == P_TRAP) ? trap_cnt + 1 : 0;
      if (trap_cnt >= 3 || $urandom_range(0, 499) == 0) begin
        do_reset();
        trap_cnt = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
